// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller:
// FSM state encoding, data/counter widths and the latency reload helper.
package mem_access_ctrl_pkg;

    localparam int MEM_DATA_W = 16;
    localparam int LAT_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // WAIT counts down to zero, then one ACCESS cycle follows,
    // so WAIT lasts LATENCY-1 cycles when loaded with LATENCY-2.
    function automatic logic [LAT_CNT_W-1:0] lat_reload(input int lat);
        if (lat >= 2)
            return LAT_CNT_W'(lat - 2);
        else
            return '0;
    endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Multi-cycle access controller between the memory stage and a
// single-cycle 16-bit data memory; stalls the pipeline for LATENCY cycles.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/wr/addr/wdata   request from the pipeline (sampled in IDLE)
//   req_ready         high in IDLE only
//   stall             freeze upstream pipeline
//   resp_done         one-cycle completion pulse
//   resp_rdata        load data, holds between loads
//   err               misaligned-access flag (0 unless MEM_ALIGN_CHECK_EN)
//   mem_enable/wr/addr/wdata  memory drive, enable/wr only in ACCESS
//   mem_rdata         combinational memory read data
//
// Build option: define MEM_ALIGN_CHECK_EN to reject odd addresses
// (straight to DONE with err=1, no memory access).
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [MEM_DATA_W-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  stall,
    output logic                  resp_done,
    output logic [MEM_DATA_W-1:0] resp_rdata,
    output logic                  err,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [MEM_DATA_W-1:0] mem_wdata,
    input  logic [MEM_DATA_W-1:0] mem_rdata
);

    localparam logic [LAT_CNT_W-1:0] CNT_RELOAD = lat_reload(LATENCY);
    localparam bit                   LAT_ONE    = (LATENCY == 1);

    state_t                  state_q;
    state_t                  state_d;
    logic [LAT_CNT_W-1:0]    cnt_q;
    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [MEM_DATA_W-1:0]   wdata_q;
    logic [MEM_DATA_W-1:0]   rdata_q;
    logic                    accept;
    logic                    misal_req;

    assign accept = (state_q == ST_IDLE) && req_valid;

`ifdef MEM_ALIGN_CHECK_EN
    logic misal_q;
    assign misal_req = req_addr[0];
`else
    assign misal_req = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (misal_req)
                        state_d = ST_DONE;
                    else if (LAT_ONE)
                        state_d = ST_ACCESS;
                    else
                        state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0)
                    state_d = ST_ACCESS;
            end
            ST_ACCESS: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Request latch, latency counter and read-data register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                wr_q    <= req_wr;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt_q   <= CNT_RELOAD;
            end
            if (state_q == ST_WAIT && cnt_q != '0)
                cnt_q <= cnt_q - LAT_CNT_W'(1);
            if (state_q == ST_ACCESS && !wr_q)
                rdata_q <= mem_rdata;
            // A rejected request returns zero data alongside err.
            if (accept && misal_req)
                rdata_q <= '0;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)
            misal_q <= 1'b0;
        else if (accept)
            misal_q <= misal_req;
    end
    assign err = (state_q == ST_DONE) && misal_q;
`else
    assign err = 1'b0;
`endif

    assign req_ready  = (state_q == ST_IDLE);
    assign stall      = accept
                      || (state_q == ST_WAIT)
                      || (state_q == ST_ACCESS);
    assign resp_done  = (state_q == ST_DONE);
    assign resp_rdata = rdata_q;

    // Gated by rst so the memory never sees an access while the
    // image is being loaded or a request is being aborted.
    assign mem_enable = (state_q == ST_ACCESS) && !rst;
    assign mem_wr     = mem_enable && wr_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (LATENCY=4 and LATENCY=1)
// against a small behavioural 16-bit word memory.
module tb_mem_access_ctrl;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic        req_valid, req_wr;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, stall, resp_done, err;
    logic [15:0] resp_rdata;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    logic        l_req_valid;
    logic [15:0] l_req_addr;
    logic        l_req_ready, l_stall, l_resp_done, l_err;
    logic [15:0] l_resp_rdata;
    logic        l_mem_enable, l_mem_wr;
    logic [15:0] l_mem_addr, l_mem_wdata, l_mem_rdata;

    logic [15:0] mem [0:32767];
    int          wr_cnt = 0;
    int          total  = 0;
    int          passed = 0;

    mem_access_ctrl #(.ADDR_WIDTH(16), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .stall(stall),
        .resp_done(resp_done), .resp_rdata(resp_rdata), .err(err),
        .mem_enable(mem_enable), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_access_ctrl #(.ADDR_WIDTH(16), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req_valid(l_req_valid), .req_wr(1'b0),
        .req_addr(l_req_addr), .req_wdata(16'h0000),
        .req_ready(l_req_ready), .stall(l_stall),
        .resp_done(l_resp_done), .resp_rdata(l_resp_rdata), .err(l_err),
        .mem_enable(l_mem_enable), .mem_wr(l_mem_wr),
        .mem_addr(l_mem_addr), .mem_wdata(l_mem_wdata),
        .mem_rdata(l_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata   = mem[mem_addr[15:1]];
    assign l_mem_rdata = mem[l_mem_addr[15:1]];

    always @(posedge clk) begin
        if (mem_enable && mem_wr) begin
            mem[mem_addr[15:1]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) begin
            passed++;
        end else begin
            $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One full request on the LATENCY=4 instance; request inputs are
    // scrambled after acceptance to prove they are latched.
    task automatic run_req(input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata,
                           input logic [15:0] exp_rd);
        int w0;
        w0 = wr_cnt;
        cyc();
        req_valid = 1'b1; req_wr = wr;
        req_addr = addr;  req_wdata = wdata;
        #1;
        chk("c0_stall", stall, 1);
        chk("c0_ready", req_ready, 1);
        chk("c0_en", mem_enable, 0);
        for (int c = 1; c <= LAT + 1; c++) begin
            cyc();
            req_valid = 1'b0; req_wr = ~wr;
            req_addr = addr ^ 16'h0030; req_wdata = ~wdata;
            #1;
            chk($sformatf("c%0d_stall", c), stall, (c <= LAT));
            chk($sformatf("c%0d_ready", c), req_ready, 0);
            chk($sformatf("c%0d_en", c), mem_enable, (c == LAT));
            chk($sformatf("c%0d_wr", c), mem_wr, (c == LAT) && wr);
            chk($sformatf("c%0d_addr", c), mem_addr, addr);
            chk($sformatf("c%0d_done", c), resp_done, (c == LAT + 1));
            chk($sformatf("c%0d_err", c), err, 0);
            if (wr)
                chk($sformatf("c%0d_wdata", c), mem_wdata, wdata);
        end
        chk("rdata", resp_rdata, exp_rd);
        chk("writes", wr_cnt - w0, wr);
        req_wr = 1'b0;
        cyc();
        #1;
        chk("idle_ready", req_ready, 1);
        chk("idle_done", resp_done, 0);
        chk("idle_rdata", resp_rdata, exp_rd);
    endtask

    initial begin
        int w0;
        rst = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0;
        req_addr = 16'h0; req_wdata = 16'h0;
        l_req_valid = 1'b0; l_req_addr = 16'h0;
        mem[16'h0010 >> 1] = 16'hBEEF;
        mem[16'h0020 >> 1] = 16'h0000;

        repeat (2) cyc();
        #1;
        chk("rst_en", mem_enable, 0);
        chk("rst_wr", mem_wr, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_done", resp_done, 0);
        chk("rst_rdata", resp_rdata, 16'h0);
        chk("rst_addr", mem_addr, 16'h0);
        chk("rst_err", err, 0);
        cyc();
        rst = 1'b0;

        // Load, with latched-request check during WAIT
        run_req(1'b0, 16'h0010, 16'h0000, 16'hBEEF);
        // Store leaves resp_rdata holding the last load value
        run_req(1'b1, 16'h0020, 16'h1234, 16'hBEEF);
        run_req(1'b0, 16'h0020, 16'h0000, 16'h1234);

        // Reset during WAIT aborts the store
        w0 = wr_cnt;
        cyc();
        req_valid = 1'b1; req_wr = 1'b1;
        req_addr = 16'h0020; req_wdata = 16'h5555;
        #1;
        chk("ab_stall", stall, 1);
        cyc();
        req_valid = 1'b0; req_wr = 1'b0;
        #1;
        chk("ab_wait_ready", req_ready, 0);
        cyc();
        rst = 1'b1;
        #1;
        chk("ab_rst_en", mem_enable, 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("ab_ready", req_ready, 1);
        chk("ab_stall0", stall, 0);
        chk("ab_done", resp_done, 0);
        chk("ab_rdata", resp_rdata, 16'h0);
        chk("ab_maddr", mem_addr, 16'h0);
        chk("ab_mwdata", mem_wdata, 16'h0);
        chk("ab_en", mem_enable, 0);
        repeat (3) cyc();
        chk("ab_nowrite", wr_cnt - w0, 0);
        run_req(1'b0, 16'h0020, 16'h0000, 16'h1234);

        // LATENCY=1 instance
        cyc();
        l_req_valid = 1'b1; l_req_addr = 16'h0010;
        #1;
        chk("l1_c0_stall", l_stall, 1);
        chk("l1_c0_en", l_mem_enable, 0);
        cyc();
        l_req_valid = 1'b0; l_req_addr = 16'h0020;
        #1;
        chk("l1_c1_en", l_mem_enable, 1);
        chk("l1_c1_stall", l_stall, 1);
        chk("l1_c1_addr", l_mem_addr, 16'h0010);
        chk("l1_c1_done", l_resp_done, 0);
        cyc();
        #1;
        chk("l1_c2_done", l_resp_done, 1);
        chk("l1_c2_rdata", l_resp_rdata, 16'hBEEF);
        chk("l1_c2_stall", l_stall, 0);
        chk("l1_c2_en", l_mem_enable, 0);
        cyc();
        #1;
        chk("l1_c3_done", l_resp_done, 0);
        chk("l1_c3_ready", l_req_ready, 1);
        chk("l1_err", l_err, 0);

        // Odd address
`ifdef MEM_ALIGN_CHECK_EN
        cyc();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0011;
        #1;
        chk("mis_c0_stall", stall, 1);
        cyc();
        req_valid = 1'b0;
        #1;
        chk("mis_done", resp_done, 1);
        chk("mis_err", err, 1);
        chk("mis_rdata", resp_rdata, 16'h0);
        chk("mis_en", mem_enable, 0);
        chk("mis_stall", stall, 0);
        cyc();
        #1;
        chk("mis_err_clr", err, 0);
        chk("mis_done_clr", resp_done, 0);
        chk("mis_ready", req_ready, 1);
`else
        run_req(1'b0, 16'h0011, 16'h0000, 16'hBEEF);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
